// File: rtl/bfs_frontier_fetch.sv
// bfs_frontier_fetch: pops frontier nodes, fetches each 8-beat node record from the cache,
// drops visited nodes and streams the neighbour IDs of unvisited ones.
module bfs_frontier_fetch #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MAX_NBR   = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        node_valid,
    input  logic [31:0] node_id,
    output logic        node_ready,
    output logic        bfs_req,
    output logic [31:0] bfs_req_addr,
    input  logic        cache_ready,
    input  logic        cache_fs,
    input  logic [63:0] cache_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_parent,
    output logic [31:0] out_nbr,
    output logic        busy,
    output logic        nbr_overflow,
    output logic [15:0] nodes_fetched,
    output logic [15:0] nodes_skipped
);
    typedef enum logic [1:0] {IDLE, WAIT, COLLECT, EMIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] parent_q, parent_d;
    logic [31:0] hdr_cnt_q, hdr_cnt_d;
    logic        vis_q, vis_d;
    logic [2:0]  beat_q, beat_d;
    logic [63:0] buf_q [7];
    logic [63:0] buf_d [7];
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        ovf_q, ovf_d;
    logic [15:0] fetched_q, fetched_d;
    logic [15:0] skipped_q, skipped_d;
    logic        too_many;
    logic [3:0]  lim;

    assign too_many      = hdr_cnt_q > 32'(MAX_NBR);
    assign lim           = too_many ? 4'(MAX_NBR) : hdr_cnt_q[3:0];
    assign node_ready    = (state_q == IDLE) && cache_ready && !rst;
    assign bfs_req       = node_valid && node_ready;
    assign bfs_req_addr  = ADDR_BASE + (node_id << 6);
    assign out_valid     = state_q == EMIT;
    assign out_parent    = parent_q;
    assign out_nbr       = idx_q[0] ? buf_q[idx_q[3:1]][63:32] : buf_q[idx_q[3:1]][31:0];
    assign busy          = state_q != IDLE;
    assign nbr_overflow  = ovf_q;
    assign nodes_fetched = fetched_q;
    assign nodes_skipped = skipped_q;

    always_comb begin
        state_d   = state_q;
        parent_d  = parent_q;
        hdr_cnt_d = hdr_cnt_q;
        vis_d     = vis_q;
        beat_d    = beat_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
        fetched_d = fetched_q;
        skipped_d = skipped_q;
        case (state_q)
            IDLE: if (bfs_req) begin
                parent_d = node_id;
                state_d  = WAIT;
            end
            WAIT: if (cache_fs) begin
                hdr_cnt_d = cache_rdata[31:0];
                vis_d     = cache_rdata[32];
                beat_d    = 3'd1;
                state_d   = COLLECT;
            end
            COLLECT: begin
                buf_d[beat_q - 3'd1] = cache_rdata;
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd7) begin
                    idx_d = '0;
                    cnt_d = lim;
                    if (vis_q) begin
                        skipped_d = skipped_q + 16'd1;
                        state_d   = IDLE;
                    end else begin
                        fetched_d = fetched_q + 16'd1;
                        ovf_d     = ovf_q | too_many;
                        state_d   = (lim == 4'd0) ? IDLE : EMIT;
                    end
                end
            end
            EMIT: if (out_ready) begin
                idx_d = idx_q + 4'd1;
                if (idx_q == cnt_q - 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            parent_q  <= '0;
            hdr_cnt_q <= '0;
            vis_q     <= 1'b0;
            beat_q    <= '0;
            for (int i = 0; i < 7; i++) buf_q[i] <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            fetched_q <= '0;
            skipped_q <= '0;
        end else begin
            state_q   <= state_d;
            parent_q  <= parent_d;
            hdr_cnt_q <= hdr_cnt_d;
            vis_q     <= vis_d;
            beat_q    <= beat_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
            fetched_q <= fetched_d;
            skipped_q <= skipped_d;
        end
    end
endmodule

// File: tb/tb_bfs_frontier_fetch.sv
// tb_bfs_frontier_fetch: directed node records with a neighbour scoreboard; a monitor
// pops expected {parent, nbr} pairs on every output handshake.
module tb_bfs_frontier_fetch;
    logic        clk = 1'b0, rst = 1'b1;
    logic        node_valid = 1'b0, cache_ready = 1'b1, cache_fs = 1'b0, out_ready = 1'b1;
    logic [31:0] node_id = '0;
    logic [63:0] cache_rdata = '0;
    logic        node_ready, bfs_req, out_valid, busy, nbr_overflow;
    logic [31:0] bfs_req_addr, out_parent, out_nbr;
    logic [15:0] nodes_fetched, nodes_skipped;

    int n_cmp = 0, n_bad = 0;
    logic [63:0] exp_q [$];
    logic        stall_mode = 1'b0;
    logic [15:0] exp_fetched = '0, exp_skipped = '0;
    logic        exp_ovf = 1'b0;

    bfs_frontier_fetch #(.ADDR_BASE(32'h0000_1000)) dut (
        .clk(clk), .rst(rst), .node_valid(node_valid), .node_id(node_id),
        .node_ready(node_ready), .bfs_req(bfs_req), .bfs_req_addr(bfs_req_addr),
        .cache_ready(cache_ready), .cache_fs(cache_fs), .cache_rdata(cache_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_parent(out_parent),
        .out_nbr(out_nbr), .busy(busy), .nbr_overflow(nbr_overflow),
        .nodes_fetched(nodes_fetched), .nodes_skipped(nodes_skipped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on handshake; stalled outputs must hold.
    initial begin
        logic        prev_stall = 1'b0;
        logic [31:0] prev_nbr = '0, prev_par = '0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (prev_stall && out_valid) begin
                check("stall_nbr_hold", out_nbr, prev_nbr);
                check("stall_parent_hold", out_parent, prev_par);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("out_parent", out_parent, e[63:32]);
                    check("out_nbr", out_nbr, e[31:0]);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_nbr   = out_nbr;
            prev_par   = out_parent;
        end
    end

    // out_ready driver: 1,0,0,1 repeating in stall mode, otherwise always ready.
    initial begin
        logic [3:0] pat = 4'b1001;
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            out_ready = stall_mode ? pat[3 - (ph % 4)] : 1'b1;
            ph++;
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Issue a node, serve its record (neighbour i = base + i), check timing and counters.
    task automatic run_node(input logic [31:0] id, input logic [31:0] cnt, input logic vis,
                            input logic [31:0] base);
        int n;
        n = vis ? 0 : ((cnt > 14) ? 14 : int'(cnt));
        for (int i = 0; i < n; i++) exp_q.push_back({id, base + 32'(i)});
        if (vis) exp_skipped++;
        else begin
            exp_fetched++;
            if (cnt > 14) exp_ovf = 1'b1;
        end
        node_valid = 1'b1; node_id = id; cache_ready = 1'b1;
        #1;
        check("bfs_req", 32'(bfs_req), 32'd1);
        check("bfs_req_addr", bfs_req_addr, 32'h1000 + (id << 6));
        tick; node_valid = 1'b0;
        check("no_req_outside_idle", 32'(bfs_req), 32'd0);
        tick; cache_fs = 1'b1; cache_rdata = {31'd0, vis, cnt};
        for (int k = 0; k < 7; k++) begin
            tick; cache_fs = 1'b0;
            cache_rdata = {base + 32'(2 * k + 1), base + 32'(2 * k)};
        end
        tick; cache_rdata = '0;
        if (n == 0) begin
            check("idle_at_T10_busy", 32'(busy), 32'd0);
            check("idle_at_T10_node_ready", 32'(node_ready), 32'd1);
        end else check("first_valid_T10", 32'(out_valid), 32'd1);
        for (int c = 0; c < 80 && busy; c++) tick;
        check("busy_drop", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("nodes_fetched", 32'(nodes_fetched), 32'(exp_fetched));
        check("nodes_skipped", 32'(nodes_skipped), 32'(exp_skipped));
        check("nbr_overflow", 32'(nbr_overflow), 32'(exp_ovf));
    endtask

    initial begin
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_node_ready", 32'(node_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fetched", 32'(nodes_fetched), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        tick;
        run_node(32'd3, 32'd5, 1'b0, 32'd10);
        run_node(32'd3, 32'd5, 1'b1, 32'd10);
        run_node(32'd7, 32'd20, 1'b0, 32'd100);
        stall_mode = 1'b1;
        run_node(32'd9, 32'd4, 1'b0, 32'd200);
        stall_mode = 1'b0;
        run_node(32'd11, 32'd0, 1'b0, 32'd0);
        cache_ready = 1'b0; node_valid = 1'b1; node_id = 32'd21;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("blocked_bfs_req", 32'(bfs_req), 32'd0);
            check("blocked_node_ready", 32'(node_ready), 32'd0);
            tick;
        end
        node_valid = 1'b0; cache_ready = 1'b1;
        check("ovf_sticky", 32'(nbr_overflow), 32'd1);
        // Abort a fetch in COLLECT after beat 4 with reset.
        node_valid = 1'b1; node_id = 32'd13;
        tick; node_valid = 1'b0;
        tick; cache_fs = 1'b1; cache_rdata = {31'd0, 1'b0, 32'd6};
        for (int k = 0; k < 4; k++) begin
            tick; cache_fs = 1'b0; cache_rdata = {32'hdead_0000 + 32'(k), 32'hbeef_0000 + 32'(k)};
        end
        tick; rst = 1'b1; node_valid = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_node_ready", 32'(node_ready), 32'd0);
        check("mid_rst_bfs_req", 32'(bfs_req), 32'd0);
        check("mid_rst_ovf", 32'(nbr_overflow), 32'd0);
        check("mid_rst_fetched", 32'(nodes_fetched), 32'd0);
        check("mid_rst_skipped", 32'(nodes_skipped), 32'd0);
        check("mid_rst_parent", out_parent, 32'd0);
        check("mid_rst_nbr", out_nbr, 32'd0);
        exp_fetched = '0; exp_skipped = '0; exp_ovf = 1'b0;
        node_valid = 1'b0; cache_rdata = '0;
        tick; rst = 1'b0;
        tick;
        run_node(32'd5, 32'd3, 1'b0, 32'd300);
        repeat (3) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
